// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - instruction fetch with a 2-entry {pc, instruction} queue
module instruction_fetch_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] PC_OUT,
    output logic [31:0] INSTRUCTION_OUT,
    output logic        BUSYWAIT
);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DISCARD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] disc_addr_q, disc_addr_d;
    logic [31:0] head_pc_q, head_pc_d, head_instr_q, head_instr_d;
    logic [31:0] tail_pc_q, tail_pc_d, tail_instr_q, tail_instr_d;

    logic read_req, complete, enq, deq;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        count_d      = count_q;
        disc_addr_d  = disc_addr_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;

        read_req = (state_q == S_FETCH) || (state_q == S_DISCARD);
        complete = read_req && !IMEM_BUSYWAIT;
        deq      = (count_q != 2'd0) && !STALL && !BRANCH_TAKEN;
        enq      = (state_q == S_FETCH) && complete && !BRANCH_TAKEN;

        if (BRANCH_TAKEN) begin
            count_d = 2'd0;
            pc_d    = BRANCH_TARGET & 32'hFFFF_FFFC;
            // An unfinished read must still be waited out, but its data is dropped.
            if (state_q == S_FETCH && IMEM_BUSYWAIT) begin
                state_d     = S_DISCARD;
                disc_addr_d = pc_q;
            end else if (state_q == S_DISCARD && IMEM_BUSYWAIT) begin
                state_d = S_DISCARD;
            end else begin
                state_d = S_FETCH;
            end
        end else begin
            unique case ({enq, deq})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_pc_d    = pc_q;
                        head_instr_d = IMEM_READDATA;
                    end else begin
                        tail_pc_d    = pc_q;
                        tail_instr_d = IMEM_READDATA;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    // Dequeuing the last entry leaves the head visible as the "last value".
                    if (count_q == 2'd2) begin
                        head_pc_d    = tail_pc_q;
                        head_instr_d = tail_instr_q;
                    end
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_pc_d    = pc_q;
                        head_instr_d = IMEM_READDATA;
                    end else begin
                        head_pc_d    = tail_pc_q;
                        head_instr_d = tail_instr_q;
                        tail_pc_d    = pc_q;
                        tail_instr_d = IMEM_READDATA;
                    end
                end
                default: ;
            endcase

            unique case (state_q)
                S_FETCH: begin
                    if (complete) begin
                        pc_d = pc_q + 32'd4;
                        if (count_d == 2'd2) state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (deq) state_d = S_FETCH;
                end
                S_DISCARD: begin
                    if (complete) state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_FETCH;
            pc_q         <= 32'd0;
            count_q      <= 2'd0;
            disc_addr_q  <= 32'd0;
            head_pc_q    <= 32'hFFFF_FFFC;
            head_instr_q <= 32'd0;
            tail_pc_q    <= 32'd0;
            tail_instr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            count_q      <= count_d;
            disc_addr_q  <= disc_addr_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
        end
    end

    assign IMEM_READ       = read_req && !RESET;
    assign IMEM_ADDRESS    = (state_q == S_DISCARD) ? disc_addr_q : pc_q;
    assign PC_OUT          = head_pc_q;
    assign INSTRUCTION_OUT = head_instr_q;
    assign BUSYWAIT        = (count_q == 2'd0);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized bench for instruction_fetch_unit against a queue model
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        STALL = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [31:0] BRANCH_TARGET = 32'd0;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA = 32'd0;
    logic        IMEM_BUSYWAIT = 1'b0;
    logic [31:0] PC_OUT;
    logic [31:0] INSTRUCTION_OUT;
    logic        BUSYWAIT;

    instruction_fetch_unit dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL),
        .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
        .IMEM_READ(IMEM_READ), .IMEM_ADDRESS(IMEM_ADDRESS),
        .IMEM_READDATA(IMEM_READDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .PC_OUT(PC_OUT), .INSTRUCTION_OUT(INSTRUCTION_OUT), .BUSYWAIT(BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    // reference model: plain queue of fetched entries plus a pending-discard flag
    logic [31:0] mq_pc[$];
    logic [31:0] mq_ins[$];
    logic [31:0] m_pc, m_daddr, m_last_pc, m_last_ins;
    bit          m_disc, model_ok;

    // memory model
    bit          mem_active;
    int          mem_left;
    logic [31:0] mem_addr;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cycle, got, exp);
        end
    endtask

    task automatic step(input bit rst, input bit stl, input bit br, input logic [31:0] tgt,
                        input int max_wait);
        bit req, busy, comp;
        #1;
        RESET = rst; STALL = stl; BRANCH_TAKEN = br; BRANCH_TARGET = tgt;
        #1;
        if (IMEM_READ) begin
            if (!mem_active) begin
                mem_active = 1;
                mem_left   = $urandom_range(max_wait, 0);
                mem_addr   = IMEM_ADDRESS;
            end else begin
                check("addr_hold", IMEM_ADDRESS, mem_addr);
            end
            IMEM_BUSYWAIT = (mem_left > 0);
            IMEM_READDATA = IMEM_BUSYWAIT ? $urandom : memword(mem_addr);
        end else begin
            if (mem_active && !rst) check("read_held", {31'd0, IMEM_READ}, 32'd1);
            mem_active    = 0;
            IMEM_BUSYWAIT = $urandom_range(1, 0);
            IMEM_READDATA = $urandom;
        end
        #1;
        req = m_disc || (mq_pc.size() < 2);
        if (model_ok) begin
            check("imem_read", {31'd0, IMEM_READ}, {31'd0, req && !rst});
            if (req && !rst) check("imem_addr", IMEM_ADDRESS, m_disc ? m_daddr : m_pc);
            check("busywait", {31'd0, BUSYWAIT}, {31'd0, mq_pc.size() == 0});
            check("pc_out", PC_OUT, m_last_pc);
            check("instr_out", INSTRUCTION_OUT, m_last_ins);
        end
        busy = IMEM_BUSYWAIT;
        @(posedge CLK);
        cycle++;
        comp = req && !busy;
        if (rst) begin
            mq_pc.delete(); mq_ins.delete();
            m_pc = 0; m_disc = 0;
            m_last_pc = 32'hFFFF_FFFC; m_last_ins = 0;
            model_ok = 1;
        end else if (model_ok) begin
            if (br) begin
                if (!m_disc && req && busy) begin
                    m_disc = 1; m_daddr = m_pc;
                end else if (m_disc && !busy) begin
                    m_disc = 0;
                end
                mq_pc.delete(); mq_ins.delete();
                m_pc = tgt & 32'hFFFF_FFFC;
            end else begin
                if (mq_pc.size() > 0 && !stl) begin
                    void'(mq_pc.pop_front()); void'(mq_ins.pop_front());
                end
                if (m_disc) begin
                    if (comp) m_disc = 0;
                end else if (comp) begin
                    mq_pc.push_back(m_pc); mq_ins.push_back(memword(m_pc));
                    m_pc = m_pc + 32'd4;
                end
            end
            if (mq_pc.size() > 0) begin
                m_last_pc = mq_pc[0]; m_last_ins = mq_ins[0];
            end
        end
        if (rst) mem_active = 0;
        else if (mem_active) begin
            if (!busy) mem_active = 0;
            else mem_left--;
        end
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(3, 0))
            0: return $urandom;
            1: return 32'h0000_0103;
            2: return 32'hFFFF_FFF0 | $urandom_range(15, 0);
            default: return $urandom_range(63, 0);
        endcase
    endfunction

    // per phase: max wait, stall %, branch %, reset %, cycles
    int ph_wait[9]  = '{0, 0, 3, 0, 0, 0, 3, 2, 0};
    int ph_stall[9] = '{0, 0, 0, 0, 100, 0, 40, 30, 20};
    int ph_br[9]    = '{0, 0, 0, 0, 0, 0, 15, 10, 25};
    int ph_rst[9]   = '{100, 0, 0, 100, 0, 0, 0, 3, 0};
    int ph_len[9]   = '{2, 12, 30, 1, 6, 6, 2000, 2000, 1000};

    initial begin
        model_ok   = 0;
        mem_active = 0;
        m_disc     = 0;
        for (int p = 0; p < 9; p++) begin
            for (int c = 0; c < ph_len[p]; c++) begin
                step($urandom_range(99, 0) < ph_rst[p],
                     $urandom_range(99, 0) < ph_stall[p],
                     $urandom_range(99, 0) < ph_br[p],
                     pick_target(), ph_wait[p]);
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
